// File: rtl/tcam_pkg.sv
// Shared FracTCAM definitions: index sizing, entry field layout and the ternary match rule.
package tcam_pkg;

  // Widest key any FracTCAM variant compares; narrower keys are zero-extended.
  localparam int TCAM_MAX_DW = 512;

  // Entry packing is {valid, key, mask}, mask in the low bits.
  localparam int TCAM_MASK_OFS = 0;

  function automatic int tcam_index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int tcam_key_ofs(input int dw);
    return dw;
  endfunction

  function automatic int tcam_valid_pos(input int dw);
    return 2 * dw;
  endfunction

  function automatic int tcam_entry_w(input int dw);
    return 2 * dw + 1;
  endfunction

  function automatic logic tcam_entry_match(input logic                   vld,
                                            input logic [TCAM_MAX_DW-1:0] key,
                                            input logic [TCAM_MAX_DW-1:0] mask,
                                            input logic [TCAM_MAX_DW-1:0] lookup);
    return vld && (((lookup ^ key) & mask) == '0);
  endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Combinational lowest-set-bit priority encoder; index is 0 when no bit is set.
module tcam_prio_enc #(
  parameter int WIDTH       = 64,
  parameter int INDEX_WIDTH = 6
) (
  input  logic [WIDTH-1:0]       vec_i,
  output logic                   hit_o,
  output logic [INDEX_WIDTH-1:0] idx_o
);

  always_comb begin
    hit_o = |vec_i;
    idx_o = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = INDEX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/tcam_match_pipe.sv
// Ternary match table with runtime writes and a 2-stage lookup pipeline (compare, then encode).
// Latency 2 cycles, 1 lookup/cycle; a stalled output holds and backs up through stage 1 to s_ready.
module tcam_match_pipe
  import tcam_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int DEPTH       = 64,
  localparam int INDEX_WIDTH = tcam_index_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_key,
  input  logic [DATA_WIDTH-1:0]  wr_mask,
  input  logic                   wr_valid,
  input  logic [DATA_WIDTH-1:0]  s_key,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DEPTH-1:0]       m_match,
  output logic                   m_hit,
  output logic [INDEX_WIDTH-1:0] m_index,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int ENTRY_W   = tcam_entry_w(DATA_WIDTH);
  localparam int KEY_OFS   = tcam_key_ofs(DATA_WIDTH);
  localparam int VALID_POS = tcam_valid_pos(DATA_WIDTH);
  localparam logic [INDEX_WIDTH:0] DEPTH_L = (INDEX_WIDTH + 1)'(DEPTH);

  logic [ENTRY_W-1:0]     entry_q [DEPTH];
  logic [DEPTH-1:0]       match_vec;
  logic                   wr_in_range;
  logic                   s2_load, s1_adv, accept;
  logic                   s1_valid_q, s1_valid_d;
  logic [DEPTH-1:0]       s1_match_q, s1_match_d;
  logic                   m_valid_q, m_valid_d;
  logic [DEPTH-1:0]       m_match_q, m_match_d;
  logic                   m_hit_q, m_hit_d;
  logic [INDEX_WIDTH-1:0] m_index_q, m_index_d;
  logic                   enc_hit;
  logic [INDEX_WIDTH-1:0] enc_idx;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else if (wr_en && wr_in_range) begin
      entry_q[wr_addr] <= {wr_valid, wr_key, wr_mask};
    end
  end

  // Compare against registered contents, so a same-cycle write is seen only by later lookups.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = tcam_entry_match(entry_q[i][VALID_POS],
                                      TCAM_MAX_DW'(entry_q[i][KEY_OFS +: DATA_WIDTH]),
                                      TCAM_MAX_DW'(entry_q[i][TCAM_MASK_OFS +: DATA_WIDTH]),
                                      TCAM_MAX_DW'(s_key));
    end
  end

  assign s2_load = !m_valid_q || m_ready;
  assign s1_adv  = s2_load || !s1_valid_q;
  assign s_ready = !rst && s1_adv;
  assign accept  = s_valid && s_ready;

  tcam_prio_enc #(
    .WIDTH      (DEPTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_prio_enc (
    .vec_i(s1_match_q),
    .hit_o(enc_hit),
    .idx_o(enc_idx)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_match_d = s1_match_q;
    m_valid_d  = m_valid_q;
    m_match_d  = m_match_q;
    m_hit_d    = m_hit_q;
    m_index_d  = m_index_q;
    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) s1_match_d = match_vec;
    end
    if (s2_load) begin
      m_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        m_match_d = s1_match_q;
        m_hit_d   = enc_hit;
        m_index_d = enc_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_match_q <= '0;
      m_valid_q  <= 1'b0;
      m_match_q  <= '0;
      m_hit_q    <= 1'b0;
      m_index_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_match_q <= s1_match_d;
      m_valid_q  <= m_valid_d;
      m_match_q  <= m_match_d;
      m_hit_q    <= m_hit_d;
      m_index_q  <= m_index_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_match = m_match_q;
  assign m_hit   = m_hit_q;
  assign m_index = m_index_q;

endmodule

// File: tb/tb_tcam_match_pipe.sv
// Scoreboard bench for tcam_match_pipe with an 8-bit key, 4-entry table.
module tb_tcam_match_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_key = '0;
  logic [7:0] wr_mask = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] s_key = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [3:0] m_match;
  logic       m_hit;
  logic [1:0] m_index;
  logic       m_valid;
  logic       m_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  logic [3:0] exp_q[$];

  logic       mv [4];
  logic [7:0] mk [4];
  logic [7:0] mm [4];

  tcam_match_pipe #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key), .wr_mask(wr_mask), .wr_valid(wr_valid),
    .s_key(s_key), .s_valid(s_valid), .s_ready(s_ready),
    .m_match(m_match), .m_hit(m_hit), .m_index(m_index), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_match(input logic [7:0] key);
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) r[i] = mv[i] && (((key ^ mk[i]) & mm[i]) == 8'h00);
    return r;
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0; mk[i] = '0; mm[i] = '0;
    end
  endtask

  // Result monitor: a transfer happens at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(m_match), 32'hFFFF_FFFF);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("match", 32'(m_match), 32'(e));
        check("hit", 32'(m_hit), 32'(|e));
        check("index", 32'(m_index), 32'(lowest(e)));
      end
    end
  end

  task automatic write_entry(input logic [1:0] a, input logic [7:0] k, input logic [7:0] m,
                             input logic v);
    wr_en = 1'b1; wr_addr = a; wr_key = k; wr_mask = m; wr_valid = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mv[a] = v; mk[a] = k; mm[a] = m;
  endtask

  task automatic send(input logic [7:0] key, input logic [3:0] exp);
    int n = 0;
    s_key = key; s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        exp_q.push_back(exp);
        acc_cnt++;
        break;
      end
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'(s_ready), 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] held;
    int acc0;
    clear_model();
    #2;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_match", 32'(m_match), 32'd0);
    check("rst_m_hit", 32'(m_hit), 32'd0);
    check("rst_m_index", 32'(m_index), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("s_ready_after_rst", 32'(s_ready), 32'd1);

    // Empty table: no hit, still a valid result, 2-cycle latency.
    send(8'h5A, 4'b0000);
    @(negedge clk);
    check("latency_c1_m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("latency_c2_m_valid", 32'(m_valid), 32'd1);
    drain();

    write_entry(2'd2, 8'h50, 8'hF0, 1'b1);
    send(8'h5A, 4'b0100);
    send(8'h6A, 4'b0000);
    drain();

    write_entry(2'd1, 8'h00, 8'h00, 1'b1);
    send(8'h5A, 4'b0110);
    drain();

    // Write of entry 0 in the same cycle as the lookup is not visible to it.
    wr_en = 1'b1; wr_addr = 2'd0; wr_key = 8'h5A; wr_mask = 8'hFF; wr_valid = 1'b1;
    s_key = 8'h5A; s_valid = 1'b1;
    @(negedge clk);
    check("collision_s_ready", 32'(s_ready), 32'd1);
    exp_q.push_back(4'b0110);
    @(posedge clk); #1;
    wr_en = 1'b0;
    mv[0] = 1'b1; mk[0] = 8'h5A; mm[0] = 8'hFF;
    s_valid = 1'b0;
    send(8'h5A, 4'b0111);
    drain();

    // Backpressure: 4 back-to-back lookups against a stalled output.
    write_entry(2'd1, 8'h00, 8'h00, 1'b0);
    acc0 = acc_cnt;
    m_ready = 1'b0;
    fork
      begin
        send(8'h5A, model_match(8'h5A));
        send(8'h13, model_match(8'h13));
        send(8'h55, model_match(8'h55));
        send(8'h6A, model_match(8'h6A));
      end
      begin
        repeat (3) @(negedge clk);
        check("stall_accepted", 32'(acc_cnt - acc0), 32'd2);
        check("stall_s_ready", 32'(s_ready), 32'd0);
        check("stall_m_valid", 32'(m_valid), 32'd1);
        held = m_match;
        @(negedge clk);
        check("stall_hold_match", 32'(m_match), 32'(held));
        check("stall_hold_valid", 32'(m_valid), 32'd1);
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    drain();
    check("stream_accepted", 32'(acc_cnt - acc0), 32'd4);

    // Asynchronous reset with two lookups in flight.
    send(8'h5A, model_match(8'h5A));
    send(8'h55, model_match(8'h55));
    #2 rst = 1'b1;
    #1;
    check("async_rst_m_valid", 32'(m_valid), 32'd0);
    exp_q.delete();
    clear_model();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(m_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(8'h5A, 4'b0000);
    send(8'h55, 4'b0000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
